mem_arbiter: RTL and testbench

- Shares the single multi-cycle-read, single-cycle-write main memory between the I-cache and D-cache miss handlers.
- Sequences a block fill as WORDS_PER_BLOCK pipelined word reads. Counts returned words and streams each one, with its word index, back to the granted requester.
- Also performs single-word D-side write-through writes.
- Sits between both cache controllers and the memory; it is the only master of the memory ports.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_fill_seq.sv | 48 ++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and derived constants for mem_arbiter
package mem_arb_pkg;

    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int WORD_IDX_W          = $clog2(DEF_WORDS_PER_BLOCK);
    localparam int BLK_OFF_BITS        = $clog2(DEF_WORDS_PER_BLOCK * 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_I  = 2'd1,
        FILL_D  = 2'd2,
        WRITE_D = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_fill_seq.sv
// rtl/mem_fill_seq.sv - block-fill sequencer: issue/return counters and word address generation
module mem_fill_seq #(
    parameter int AWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              active,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              mem_data_valid,
    output logic              issue_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [IDX_W-1:0]  word_idx,
    output logic              last
);

    localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'(WORDS_PER_BLOCK * 2 - 1);

    logic [AWIDTH-1:0] base_q;
    logic [IDX_W:0]    issue_cnt;
    logic [IDX_W-1:0]  ret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (start) begin
            base_q    <= base_addr & ~OFF_MASK;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (active) begin
            if (issue_en)
                issue_cnt <= issue_cnt + (IDX_W+1)'(1);
            if (mem_data_valid)
                ret_cnt <= ret_cnt + IDX_W'(1);
        end
    end

    // Offset bits of base_q are zero, so OR keeps every word inside the block.
    assign issue_en = active && !issue_cnt[IDX_W];
    assign mem_addr = base_q | AWIDTH'({issue_cnt[IDX_W-1:0], 1'b0});
    assign word_idx = ret_cnt;
    assign last     = active && mem_data_valid && (ret_cnt == IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache miss arbiter and sole master of main memory
// Define ARB_RR_EN for round-robin on simultaneous requests (default: D over I).
module mem_arbiter #(
    parameter int AWIDTH          = 16,
    parameter int DWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_req,
    input  logic [AWIDTH-1:0]                  i_addr,
    output logic                               i_grant,
    output logic [DWIDTH-1:0]                  i_data,
    output logic                               i_data_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] i_word_idx,
    output logic                               i_done,
    input  logic                               d_req,
    input  logic                               d_wr,
    input  logic [AWIDTH-1:0]                  d_addr,
    input  logic [DWIDTH-1:0]                  d_wdata,
    output logic                               d_grant,
    output logic [DWIDTH-1:0]                  d_data,
    output logic                               d_data_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] d_word_idx,
    output logic                               d_done,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [AWIDTH-1:0]                  mem_addr,
    output logic [DWIDTH-1:0]                  mem_data_in,
    input  logic [DWIDTH-1:0]                  mem_data_out,
    input  logic                               mem_data_valid
);
    import mem_arb_pkg::*;

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    if (MEM_LATENCY < 1 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_cfg
        $error("mem_arbiter: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK a power of 2");
    end

    arb_state_t        state_q, state_d;
    req_id_t           winner;
    logic              any_req, start, fill_active;
    logic              grant_i_q, grant_d_q;
    logic [AWIDTH-1:0] waddr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              seq_issue, seq_last;
    logic [AWIDTH-1:0] seq_addr;
    logic [IDX_W-1:0]  seq_idx;

    assign any_req = i_req || d_req;

`ifdef ARB_RR_EN
    req_id_t last_q;

    always_comb begin
        winner = d_req ? REQ_D : REQ_I;
        if (i_req && d_req)
            winner = (last_q == REQ_I) ? REQ_D : REQ_I;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= REQ_I;
        else if (state_q == IDLE && any_req)
            last_q <= winner;
    end
`else
    assign winner = d_req ? REQ_D : REQ_I;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (any_req)
                                state_d = (winner == REQ_D) ? (d_wr ? WRITE_D : FILL_D) : FILL_I;
            FILL_I, FILL_D: if (seq_last) state_d = IDLE;
            WRITE_D:        state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign start       = (state_q == IDLE) && (state_d == FILL_I || state_d == FILL_D);
    assign fill_active = (state_q == FILL_I) || (state_q == FILL_D);

    // Grants are registered so they land in the first cycle of the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_i_q <= 1'b0;
            grant_d_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            grant_i_q <= (state_q == IDLE) && (state_d == FILL_I);
            grant_d_q <= (state_q == IDLE) && (state_d == FILL_D || state_d == WRITE_D);
            if (state_q == IDLE && state_d == WRITE_D) begin
                waddr_q <= d_addr & ~AWIDTH'(1);
                wdata_q <= d_wdata;
            end
        end
    end

    mem_fill_seq #(
        .AWIDTH          (AWIDTH),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .IDX_W           (IDX_W)
    ) u_fill_seq (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .active         (fill_active),
        .base_addr      ((winner == REQ_D) ? d_addr : i_addr),
        .mem_data_valid (mem_data_valid),
        .issue_en       (seq_issue),
        .mem_addr       (seq_addr),
        .word_idx       (seq_idx),
        .last           (seq_last)
    );

    assign i_grant = grant_i_q;
    assign d_grant = grant_d_q;

    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_word_idx   = '0;
        i_done       = 1'b0;
        d_data       = '0;
        d_data_valid = 1'b0;
        d_word_idx   = '0;
        d_done       = 1'b0;
        case (state_q)
            FILL_I: begin
                mem_enable   = seq_issue;
                mem_addr     = seq_issue ? seq_addr : '0;
                i_data_valid = mem_data_valid;
                i_data       = mem_data_valid ? mem_data_out : '0;
                i_word_idx   = mem_data_valid ? seq_idx : '0;
                i_done       = seq_last;
            end
            FILL_D: begin
                mem_enable   = seq_issue;
                mem_addr     = seq_issue ? seq_addr : '0;
                d_data_valid = mem_data_valid;
                d_data       = mem_data_valid ? mem_data_out : '0;
                d_word_idx   = mem_data_valid ? seq_idx : '0;
                d_done       = seq_last;
            end
            WRITE_D: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = waddr_q;
                mem_data_in = wdata_q;
                d_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WPB = 8;
    localparam int LAT = 4;
    localparam int IW  = $clog2(WPB);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_grant, i_data_valid, i_done;
    logic          d_grant, d_data_valid, d_done;
    logic [DW-1:0] i_data, d_data;
    logic [IW-1:0] i_word_idx, d_word_idx;
    logic          mem_enable, mem_wr, mem_data_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
        .i_data_valid(i_data_valid), .i_word_idx(i_word_idx), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
        .d_word_idx(d_word_idx), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word array plus a LAT-deep read pipeline cleared by rst.
    logic [DW-1:0] mem [0:32767];
    bit            mem_loaded = 1'b0;
    logic [LAT-1:0] pv;
    logic [DW-1:0] pd [LAT];
    logic          spur = 1'b0;
    logic [DW-1:0] spur_data = '0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int n = 0; n < 32768; n++) mem[n] <= 16'(n);
            mem_loaded <= 1'b1;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[15:1]] <= mem_data_in;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], mem_enable && !mem_wr};
            pd[0] <= mem[mem_addr[15:1]];
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end

    assign mem_data_valid = pv[LAT-1] | spur;
    assign mem_data_out   = spur ? spur_data : pd[LAT-1];

    // Transaction-level reference: each accepted request produces a fixed timeline relative to t0.
    typedef struct {
        bit            side;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            t0;
    } xact_t;

    xact_t         q[$];
    logic [DW-1:0] refmem [0:32767];
    bit            last_d = 1'b0;

    function automatic int dur(input xact_t x);
        return x.wr ? 2 : (WPB + LAT + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic          eg[2], ev[2], edn[2];
        logic [DW-1:0] edat[2];
        logic [IW-1:0] eidx[2];
        logic          een, ewr;
        logic [AW-1:0] ea, base;
        logic [DW-1:0] ein;
        int            m, k;
        for (int s = 0; s < 2; s++) begin
            eg[s] = 0; ev[s] = 0; edn[s] = 0; edat[s] = '0; eidx[s] = '0;
        end
        een = 0; ewr = 0; ea = '0; ein = '0;
        foreach (q[j]) begin
            m = cyc - q[j].t0;
            if (m == 1) eg[q[j].side] = 1;
            if (q[j].wr) begin
                if (m == 1) begin
                    een = 1; ewr = 1; ea = q[j].addr & 16'hFFFE; ein = q[j].wdata; edn[1] = 1;
                end
            end else begin
                base = q[j].addr - (q[j].addr % 16'(WPB * 2));
                if (m >= 1 && m <= WPB) begin
                    een = 1; ea = base + 16'(2 * (m - 1));
                end
                if (m >= 1 + LAT && m <= LAT + WPB) begin
                    k = m - 1 - LAT;
                    ev[q[j].side]   = 1;
                    edat[q[j].side] = refmem[int'(base / 2) + k];
                    eidx[q[j].side] = IW'(k);
                    if (k == WPB - 1) edn[q[j].side] = 1;
                end
            end
        end
        check("i_grant", i_grant, eg[0]);           check("d_grant", d_grant, eg[1]);
        check("i_data_valid", i_data_valid, ev[0]); check("d_data_valid", d_data_valid, ev[1]);
        check("i_data", i_data, edat[0]);           check("d_data", d_data, edat[1]);
        check("i_word_idx", i_word_idx, eidx[0]);   check("d_word_idx", d_word_idx, eidx[1]);
        check("i_done", i_done, edn[0]);            check("d_done", d_done, edn[1]);
        check("mem_enable", mem_enable, een);       check("mem_wr", mem_wr, ewr);
        check("mem_addr", mem_addr, ea);            check("mem_data_in", mem_data_in, ein);
    endtask

    task automatic step(input bit sp);
        @(negedge clk);
        check_outputs();
        foreach (q[j])
            if (q[j].wr && cyc - q[j].t0 == 1) refmem[q[j].addr[15:1]] = q[j].wdata;
        if (i_grant) i_req = 1'b0;
        if (d_grant) d_req = 1'b0;
        while (q.size() > 0 && cyc >= q[0].t0 + dur(q[0])) void'(q.pop_front());
        spur      = sp;
        spur_data = DW'($urandom);
    endtask

    task automatic drain();
        while (q.size() > 0) step(1'b0);
    endtask

    task automatic drive(input bit side, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (side) begin
            d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
    endtask

    task automatic launch(input bit side, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        xact_t x;
        x.side = side; x.wr = side ? wr : 1'b0; x.addr = a; x.wdata = wd; x.t0 = cyc;
        q.push_back(x);
        last_d = side;
        drive(side, x.wr, a, wd);
    endtask

    task automatic collide(input bit dwr, input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd);
        xact_t xi, xd;
        bit    win_d;
        xi.side = 0; xi.wr = 0;   xi.addr = ai; xi.wdata = '0;
        xd.side = 1; xd.wr = dwr; xd.addr = ad; xd.wdata = wd;
`ifdef ARB_RR_EN
        win_d = !last_d;
`else
        win_d = 1'b1;
`endif
        if (win_d) begin
            xd.t0 = cyc; xi.t0 = cyc + dur(xd);
            q.push_back(xd); q.push_back(xi);
            last_d = 1'b0;
        end else begin
            xi.t0 = cyc; xd.t0 = cyc + dur(xi);
            q.push_back(xi); q.push_back(xd);
            last_d = 1'b1;
        end
        drive(1'b0, 1'b0, ai, '0);
        drive(1'b1, dwr, ad, wd);
    endtask

    initial begin
        int t0;
        logic [AW-1:0] ra;
        for (int n = 0; n < 32768; n++) refmem[n] = 16'(n);
        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) step(1'b0);
        rst = 1'b0;
        step(1'b0);

        collide(1'b0, 16'h0200, 16'h0300, '0); drain();
        collide(1'b0, 16'h0210, 16'h0310, '0); drain();

        launch(1'b0, 1'b0, 16'h0046, '0); drain();
        launch(1'b1, 1'b1, 16'h1234, 16'hBEEF); drain();
        launch(1'b1, 1'b0, 16'h1230, '0); drain();
        launch(1'b0, 1'b0, 16'hFFF8, '0); drain();

        repeat (6) step(1'b1);
        step(1'b0);
        launch(1'b1, 1'b0, 16'h0080, '0); drain();

        t0 = cyc;
        launch(1'b0, 1'b0, 16'h0100, '0);
        while (cyc < t0 + 6) step(1'b0);
        rst = 1'b1; i_req = 1'b0; q.delete(); last_d = 1'b0;
        #1 check_outputs();
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (4) step(1'b0);
        launch(1'b1, 1'b0, 16'h0104, '0); drain();

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)));
            step(1'b0);
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: launch(1'b0, 1'b0, ra, '0);
                1: launch(1'b1, 1'b0, ra, '0);
                2: launch(1'b1, 1'b1, ra, DW'($urandom));
                default: collide(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), ra, DW'($urandom));
            endcase
            drain();
        end
        repeat (2) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
